// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU controller: opcodes, datapath
// control encodings and the controller state enum (also used by the debugger).
package cpu_pkg;

  // Opcodes (instruction bits [15:12])
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_MOV  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_LDR  = 4'h7;
  localparam logic [3:0] OP_STR  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  // alu_func encodings
  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_AND    = 4'd2;
  localparam logic [3:0] ALU_OR     = 4'd3;
  localparam logic [3:0] ALU_PASS_B = 4'd4;

  // alu_in_sel encodings
  localparam logic [1:0] AIN_RD_RS  = 2'b00;
  localparam logic [1:0] AIN_RD_OFF = 2'b01;
  localparam logic [1:0] AIN_RS_LDR = 2'b10;

  // ldr_sel encodings
  localparam logic [1:0] LDR_NONE  = 2'b00;
  localparam logic [1:0] LDR_LOAD  = 2'b01;
  localparam logic [1:0] LDR_STORE = 2'b10;

  // pc_ctrl encodings
  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_REL  = 2'b10;

  // en_in encodings
  localparam logic [1:0] EN_IDLE  = 2'b00;
  localparam logic [1:0] EN_START = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_EXEC  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_PCUPD = 3'd5,
    ST_HALT  = 3'd6,
    ST_ERROR = 3'd7
  } ctrl_state_e;

  // True for opcodes that need a datapath pipeline run (ADD..STR)
  function automatic logic is_dp_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_STR);
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational decode of the instruction register into datapath control fields.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output logic [1:0]  rd,
  output logic [1:0]  rs,
  output logic [7:0]  offset,
  output logic [15:0] ldr_offset,
  output logic [1:0]  alu_in_sel,
  output logic [3:0]  alu_func,
  output logic [1:0]  ldr_sel,
  output logic [4:0]  reg_en,
  output logic        is_jmp
);

  logic [3:0] op;
  logic [3:0] rd_onehot;

  assign op         = ir[15:12];
  assign rd         = ir[11:10];
  assign rs         = ir[9:8];
  assign offset     = ir[7:0];
  assign ldr_offset = {{8{ir[7]}}, ir[7:0]};
  assign is_jmp     = (op == OP_JMP);

  // One-hot register write select from the rd field
  always_comb begin
    rd_onehot = 4'b0000;
    case (ir[11:10])
      2'd0:    rd_onehot = 4'b0001;
      2'd1:    rd_onehot = 4'b0010;
      2'd2:    rd_onehot = 4'b0100;
      2'd3:    rd_onehot = 4'b1000;
      default: rd_onehot = 4'b0000;
    endcase
  end

  // Opcode table: ALU function, operand select, load/store and write enables
  always_comb begin
    alu_func   = ALU_ADD;
    alu_in_sel = AIN_RD_RS;
    ldr_sel    = LDR_NONE;
    reg_en     = 5'b00000;
    case (op)
      OP_ADD:  begin alu_func = ALU_ADD;    reg_en = {1'b1, rd_onehot}; end
      OP_SUB:  begin alu_func = ALU_SUB;    reg_en = {1'b1, rd_onehot}; end
      OP_AND:  begin alu_func = ALU_AND;    reg_en = {1'b1, rd_onehot}; end
      OP_OR:   begin alu_func = ALU_OR;     reg_en = {1'b1, rd_onehot}; end
      OP_MOV:  begin alu_func = ALU_PASS_B; reg_en = {1'b0, rd_onehot}; end
      OP_ADDI: begin
        alu_func   = ALU_ADD;
        alu_in_sel = AIN_RD_OFF;
        reg_en     = {1'b0, rd_onehot};
      end
      OP_LDR:  begin
        alu_func   = ALU_ADD;
        alu_in_sel = AIN_RS_LDR;
        ldr_sel    = LDR_LOAD;
        reg_en     = {1'b0, rd_onehot};
      end
      OP_STR:  begin
        alu_func   = ALU_ADD;
        alu_in_sel = AIN_RS_LDR;
        ldr_sel    = LDR_STORE;
      end
      default: begin
        alu_func = ALU_ADD;
        reg_en   = 5'b00000;
      end
    endcase
  end

endmodule

// File: rtl/ctrl_unit.sv
// Fetch/decode/sequencing controller driving the data_path control inputs.
// Owns the FSM, the instruction register and the WAIT watchdog.
module ctrl_unit
  import cpu_pkg::*;
#(
  parameter int unsigned WDOG_MAX = 255
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] instr_data,
  input  logic        en_out,
  input  logic [15:0] pc_out,
  output logic [15:0] instr_addr,
  output logic        instr_rd,
  output logic        en_pc,
  output logic [1:0]  pc_ctrl,
  output logic [7:0]  offset,
  output logic [1:0]  en_in,
  output logic [4:0]  reg_en,
  output logic [1:0]  rd,
  output logic [1:0]  rs,
  output logic [1:0]  alu_in_sel,
  output logic [3:0]  alu_func,
  output logic [1:0]  ldr_sel,
  output logic [15:0] ldr_offset,
  output logic        halted,
  output logic        err
);

  localparam logic [7:0] WDOG_LIMIT = 8'(WDOG_MAX);

  ctrl_state_e state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  wdog_q, wdog_d;
  logic [7:0]  wdog_inc;
  logic [3:0]  latch_op;
  logic        is_jmp;

  assign latch_op = instr_data[15:12];
  assign wdog_inc = wdog_q + 8'd1;

  // Decoded fields come from the IR only, so they stay stable from EXEC to PCUPD
  instr_decoder u_dec (
    .ir         (ir_q),
    .rd         (rd),
    .rs         (rs),
    .offset     (offset),
    .ldr_offset (ldr_offset),
    .alu_in_sel (alu_in_sel),
    .alu_func   (alu_func),
    .ldr_sel    (ldr_sel),
    .reg_en     (reg_en),
    .is_jmp     (is_jmp)
  );

  // State, instruction register and watchdog flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ir_q    <= 16'h0000;
      wdog_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      wdog_q  <= wdog_d;
    end
  end

  // Next-state, IR capture and watchdog counting
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    wdog_d  = wdog_q;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
        else     state_d = ST_IDLE;
      end
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: begin
        ir_d = instr_data;
        if (latch_op == OP_HALT)    state_d = ST_HALT;
        else if (is_dp_op(latch_op)) state_d = ST_EXEC;
        else                        state_d = ST_PCUPD;
      end
      ST_EXEC: begin
        wdog_d  = 8'h00;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        wdog_d = wdog_inc;
        // A completion in the expiry cycle still counts as completion
        if (en_out)                        state_d = ST_PCUPD;
        else if (wdog_inc == WDOG_LIMIT)   state_d = ST_ERROR;
        else                               state_d = ST_WAIT;
      end
      ST_PCUPD: begin
        if (run) state_d = ST_FETCH;
        else     state_d = ST_IDLE;
      end
      ST_HALT:  state_d = ST_HALT;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Strobes and status decoded from the state register
  always_comb begin
    instr_addr = 16'h0000;
    instr_rd   = 1'b0;
    en_in      = EN_IDLE;
    en_pc      = 1'b0;
    pc_ctrl    = PC_HOLD;
    halted     = 1'b0;
    err        = 1'b0;
    case (state_q)
      ST_FETCH: begin
        instr_addr = pc_out;
        instr_rd   = 1'b1;
      end
      ST_EXEC:  en_in = EN_START;
      ST_PCUPD: begin
        en_pc   = 1'b1;
        pc_ctrl = is_jmp ? PC_REL : PC_INC;
      end
      ST_HALT:  halted = 1'b1;
      ST_ERROR: err    = 1'b1;
      default:  instr_rd = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ctrl_unit.sv
// Scoreboard bench for ctrl_unit: the stimulus process plays instruction memory
// and the datapath, pushing expected control fields per instruction; a monitor
// pops and compares them whenever the DUT strobes en_in, en_pc or instr_rd.
module tb_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst, run, en_out;
  logic [15:0] instr_data, pc_out;
  logic [15:0] instr_addr, ldr_offset;
  logic        instr_rd, en_pc, halted, err;
  logic [1:0]  pc_ctrl, en_in, rd, rs, alu_in_sel, ldr_sel;
  logic [7:0]  offset;
  logic [4:0]  reg_en;
  logic [3:0]  alu_func;

  ctrl_unit #(.WDOG_MAX(255)) dut (
    .clk(clk), .rst(rst), .run(run), .instr_data(instr_data), .en_out(en_out),
    .pc_out(pc_out), .instr_addr(instr_addr), .instr_rd(instr_rd), .en_pc(en_pc),
    .pc_ctrl(pc_ctrl), .offset(offset), .en_in(en_in), .reg_en(reg_en), .rd(rd),
    .rs(rs), .alu_in_sel(alu_in_sel), .alu_func(alu_func), .ldr_sel(ldr_sel),
    .ldr_offset(ldr_offset), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [40:0] f;
    logic        dp;
    logic [1:0]  ctrl;
    logic [7:0]  off;
  } pcx_t;

  logic [40:0] exec_q[$];
  pcx_t        pc_q[$];
  logic [15:0] addr_q[$];
  logic [15:0] m_pc;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fetch_cyc = 0;
  int eo_cyc = 0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected fields from the opcode table: {rd,rs,alu_in_sel,alu_func,ldr_sel,ldr_offset,reg_en,offset}
  function automatic logic [40:0] model_fields(input logic [15:0] ins);
    int op;
    logic [3:0] fn;
    logic [1:0] ais, ls;
    logic [4:0] re;
    op = int'(ins[15:12]);
    fn = 4'd0; ais = 2'b00; ls = 2'b00; re = 5'b00000;
    if (op >= 1 && op <= 5) fn = 4'(op - 1);
    if (op == 6) ais = 2'b01;
    if (op == 7 || op == 8) ais = 2'b10;
    if (op == 7) ls = 2'b01;
    if (op == 8) ls = 2'b10;
    if (op >= 1 && op <= 7) re[ins[11:10]] = 1'b1;
    if (op >= 1 && op <= 4) re[4] = 1'b1;
    return {ins[11:10], ins[9:8], ais, fn, ls, {{8{ins[7]}}, ins[7:0]}, re, ins[7:0]};
  endfunction

  function automatic logic [40:0] dut_fields();
    return {rd, rs, alu_in_sel, alu_func, ldr_sel, ldr_offset, reg_en, offset};
  endfunction

  function automatic logic [79:0] outs_vec();
    return 80'({instr_addr, instr_rd, en_pc, pc_ctrl, offset, en_in, reg_en, rd, rs,
                alu_in_sel, alu_func, ldr_sel, ldr_offset, halted, err});
  endfunction

  // Datapath PC model: applies en_pc at the end of the PCUPD cycle
  initial begin : pc_model
    logic [15:0] nxt;
    pc_out = 16'h0000;
    forever begin
      @(negedge clk);
      if (rst) begin
        pc_out = 16'h0000;
      end else if (en_pc) begin
        if (pc_ctrl == 2'b10)      nxt = pc_out + {{8{offset[7]}}, offset};
        else if (pc_ctrl == 2'b01) nxt = pc_out + 16'd1;
        else                       nxt = pc_out;
        @(posedge clk);
        #1;
        if (!rst) pc_out = nxt;
      end
    end
  end

  // Monitor: compare DUT strobes against the scoreboard queues
  initial begin : monitor
    logic [40:0] ef;
    pcx_t        ep;
    logic [15:0] ea;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (en_out) eo_cyc = cyc;
        if (instr_rd) begin
          fetch_cyc = cyc;
          if (addr_q.size() == 0) chk("unexpected_fetch", 80'(instr_addr), 80'(16'hxxxx));
          else begin
            ea = addr_q.pop_front();
            chk("fetch_addr", 80'(instr_addr), 80'(ea));
          end
        end
        if (en_in != 2'b00) begin
          if (exec_q.size() == 0) chk("unexpected_en_in", 80'(en_in), 80'(0));
          else begin
            ef = exec_q.pop_front();
            chk("en_in_code", 80'(en_in), 80'(2'b01));
            chk("exec_fields", 80'(dut_fields()), 80'(ef));
            chk("en_in_latency", 80'(cyc - fetch_cyc), 80'(2));
          end
        end
        if (en_pc) begin
          if (pc_q.size() == 0) chk("unexpected_en_pc", 80'(en_pc), 80'(0));
          else begin
            ep = pc_q.pop_front();
            chk("pc_ctrl", 80'(pc_ctrl), 80'(ep.ctrl));
            chk("pc_offset", 80'(offset), 80'(ep.off));
            chk("status_at_pcupd", 80'({halted, err}), 80'(0));
            if (ep.dp) begin
              chk("fields_held", 80'(dut_fields()), 80'(ep.f));
              chk("en_pc_after_en_out", 80'(cyc - eo_cyc), 80'(1));
            end else begin
              chk("nondp_latency", 80'(cyc - fetch_cyc), 80'(2));
            end
          end
        end
      end
    end
  end

  // Drive one instruction; n = datapath WAIT cycles (0 = never complete)
  task automatic issue(input logic [15:0] ins, input int n, input bit drop_run);
    logic [3:0]  op;
    logic [15:0] nxt;
    pcx_t        e;
    int          k;
    bit          got;
    op = ins[15:12];
    got = 1'b0;
    k = 0;
    while (!got && k < 40) begin
      @(negedge clk);
      got = instr_rd;
      k++;
    end
    chk("fetch_seen", 80'(got), 80'(1));
    if (!got) return;
    @(posedge clk);
    #1 instr_data = ins;
    if (op != 4'hF) begin
      e.f    = model_fields(ins);
      e.dp   = (op >= 4'h1 && op <= 4'h8);
      e.ctrl = (op == 4'h9) ? 2'b10 : 2'b01;
      e.off  = ins[7:0];
      if (e.dp) exec_q.push_back(e.f);
      pc_q.push_back(e);
      nxt = (op == 4'h9) ? m_pc + {{8{ins[7]}}, ins[7:0]} : m_pc + 16'd1;
      m_pc = nxt;
      addr_q.push_back(nxt);
    end
    @(posedge clk);
    #1 instr_data = 16'($urandom);
    if (op >= 4'h1 && op <= 4'h8) begin
      if (n == 0) return;
      @(posedge clk);
      #1;
      if (drop_run) run = 1'b0;
      repeat (n - 1) @(posedge clk);
      #1 en_out = 1'b1;
      @(posedge clk);
      #1 en_out = 1'b0;
    end
    if (op != 4'hF) begin
      k = 0;
      while (pc_q.size() != 0 && k < 20) begin
        @(negedge clk);
        k++;
      end
      chk("en_pc_seen", 80'(pc_q.size()), 80'(0));
    end
  endtask

  // Asynchronous reset pulse away from clock edges, flushing the scoreboard
  task automatic do_reset();
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs", outs_vec(), 80'(0));
    exec_q.delete();
    pc_q.delete();
    addr_q.delete();
    en_out = 1'b0;
    m_pc = 16'h0000;
    addr_q.push_back(16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : stim
    logic [3:0]  rop;
    logic [15:0] ins;
    int k, bad;
    rst = 1'b1; run = 1'b0; en_out = 1'b0; instr_data = 16'h0000;
    #2 chk("reset_outputs", outs_vec(), 80'(0));
    m_pc = 16'h0000;
    addr_q.push_back(16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run = 1'b1;

    issue(16'h1600, 3, 1'b0);   // ADD r1,r2
    issue(16'h7DFE, 1, 1'b0);   // LDR r3,[r1-2]
    issue(16'h90FC, 0, 1'b0);   // JMP -4
    issue(16'h8123, 2, 1'b0);   // STR

    for (int i = 0; i < 30; i++) begin
      rop = 4'($urandom_range(0, 14));
      ins = {rop, 12'($urandom)};
      issue(ins, $urandom_range(1, 5), 1'b0);
    end

    // completion on the last permitted WAIT cycle beats the watchdog
    issue(16'h2A00, 255, 1'b0);
    chk("no_err_at_boundary", 80'(err), 80'(0));

    // run dropped mid-WAIT: instruction completes, then the core idles
    issue(16'h3500, 2, 1'b1);
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (instr_rd) bad++;
    end
    chk("idle_after_run_drop", 80'(bad), 80'(0));
    run = 1'b1;
    issue(16'h6C7F, 1, 1'b0);

    // watchdog: no completion at all
    issue(16'h1500, 0, 1'b0);
    k = 0;
    while (k < 400) begin
      @(negedge clk);
      if (err) break;
      k++;
    end
    chk("wdog_expiry_cycle", 80'(k), 80'(256));
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!err || instr_rd || en_pc || en_in != 2'b00 || halted) bad++;
    end
    chk("err_sticky_quiet", 80'(bad), 80'(0));
    do_reset();

    // reset in the middle of WAIT
    issue(16'h4900, 0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    do_reset();
    issue(16'h5B00, 2, 1'b0);

    // HALT holds until reset
    issue(16'hF000, 0, 1'b0);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!halted || en_pc || en_in != 2'b00 || instr_rd || err) bad++;
    end
    chk("halt_sticky_quiet", 80'(bad), 80'(0));
    run = 1'b0;
    do_reset();
    repeat (3) @(negedge clk);
    chk("idle_after_final_reset", outs_vec(), 80'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : global_timeout
    #300000;
    failures++;
    $display("FAIL global_timeout: simulation still running at t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
